// File: rtl/local_mem_pipe_pkg.sv
// local_mem_pkg: shared definitions for the local_mem_pipe line memory model.
//   clog2                 - constant-friendly ceiling log2
//   rsp_entry_t           - response FIFO entry (data, tag) at default widths
//   LOCAL_MEM_LFSR_SEED   - seed of the optional request-stall LFSR
//   LOCAL_MEM_MAX_LATENCY - upper bound for the LATENCY parameter
// Default widths follow VX_MEM_*_WIDTH when those macros are defined.
`ifndef VX_MEM_DATA_WIDTH
`define VX_MEM_DATA_WIDTH 32
`endif
`ifndef VX_MEM_ADDR_WIDTH
`define VX_MEM_ADDR_WIDTH 32
`endif
`ifndef VX_MEM_TAG_WIDTH
`define VX_MEM_TAG_WIDTH 8
`endif

package local_mem_pkg;

  localparam int unsigned LOCAL_MEM_DEF_DATA_WIDTH = `VX_MEM_DATA_WIDTH;
  localparam int unsigned LOCAL_MEM_DEF_ADDR_WIDTH = `VX_MEM_ADDR_WIDTH;
  localparam int unsigned LOCAL_MEM_DEF_TAG_WIDTH  = `VX_MEM_TAG_WIDTH;

  localparam logic [15:0] LOCAL_MEM_LFSR_SEED   = 16'hACE1;
  localparam int unsigned LOCAL_MEM_MAX_LATENCY = 16;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

  typedef struct packed {
    logic [LOCAL_MEM_DEF_DATA_WIDTH-1:0] data;
    logic [LOCAL_MEM_DEF_TAG_WIDTH-1:0]  tag;
  } rsp_entry_t;

endpackage

// File: rtl/local_mem_pipe_if.sv
// local_mem_pipe_if: Vortex memory port (request + response channels).
//   master modport: drives mem_req_* and mem_rsp_ready (the requester).
//   slave modport : drives mem_req_ready and mem_rsp_* (the memory).
interface local_mem_pipe_if
  import local_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = LOCAL_MEM_DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = LOCAL_MEM_DEF_ADDR_WIDTH,
  parameter int unsigned TAG_WIDTH  = LOCAL_MEM_DEF_TAG_WIDTH
);
  logic                    mem_req_valid;
  logic                    mem_req_rw;
  logic [DATA_WIDTH/8-1:0] mem_req_byteen;
  logic [ADDR_WIDTH-1:0]   mem_req_addr;
  logic [DATA_WIDTH-1:0]   mem_req_data;
  logic [TAG_WIDTH-1:0]    mem_req_tag;
  logic                    mem_req_ready;
  logic                    mem_rsp_valid;
  logic [DATA_WIDTH-1:0]   mem_rsp_data;
  logic [TAG_WIDTH-1:0]    mem_rsp_tag;
  logic                    mem_rsp_ready;

  modport master (
    output mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr,
           mem_req_data, mem_req_tag, mem_rsp_ready,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_tag
  );

  modport slave (
    input  mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr,
           mem_req_data, mem_req_tag, mem_rsp_ready,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_tag
  );
endinterface

// File: rtl/local_mem_pipe_rsp_fifo.sv
// local_mem_rsp_fifo: synchronous FIFO with a registered head entry.
//   clk, reset (sync, active-low), push/push_entry, pop
//   head  - registered oldest entry ('0 when empty)
//   full, empty - derived from wrap-bit pointers
module local_mem_rsp_fifo
  import local_mem_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter type         entry_t = rsp_entry_t
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  entry_t push_entry,
  input  logic   pop,
  output entry_t head,
  output logic   full,
  output logic   empty
);
  localparam int unsigned PW = clog2(DEPTH);

  entry_t      mem_q [DEPTH];
  logic [PW:0] wr_ptr, rd_ptr, wr_next, rd_next;
  logic        push_ok, pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_next = wr_ptr + {{PW{1'b0}}, push_ok};
    rd_next = rd_ptr + {{PW{1'b0}}, pop_ok};
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr[PW-1:0]] <= push_entry;
  end

  // Head is preloaded with whatever becomes oldest after this edge; when the
  // entry being pushed is that one, bypass the array.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      head   <= '0;
    end else begin
      wr_ptr <= wr_next;
      rd_ptr <= rd_next;
      if (rd_next == wr_next)
        head <= '0;
      else if (push_ok && (rd_next == wr_ptr))
        head <= push_entry;
      else
        head <= mem_q[rd_next[PW-1:0]];
    end
  end
endmodule

// File: rtl/local_mem_pipe.sv
// local_mem_pipe: line-addressed memory model on the Vortex memory port with
// configurable read latency, credit-limited outstanding reads, byte-enable
// writes and sticky out-of-bounds detection.
//   clk     - clock, rising edge
//   reset   - synchronous, active-low
//   bus     - local_mem_pipe_if.slave (mem_req_* / mem_rsp_*)
//   oob_err - sticky: an out-of-bounds access was accepted
// Optional: define LOCAL_MEM_STALL_EN to stall requests pseudo-randomly
// (16-bit LFSR, ready dropped when LFSR[1:0]==0).
module local_mem_pipe
  import local_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = LOCAL_MEM_DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH      = LOCAL_MEM_DEF_ADDR_WIDTH,
  parameter int unsigned TAG_WIDTH       = LOCAL_MEM_DEF_TAG_WIDTH,
  parameter int unsigned DEPTH           = 1024,
  parameter int unsigned LATENCY         = 4,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic             clk,
  input  logic             reset,
  local_mem_pipe_if.slave  bus,
  output logic             oob_err
);
  localparam int unsigned IDX_W = clog2(DEPTH);
  localparam int unsigned CNT_W = clog2(MAX_OUTSTANDING) + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [TAG_WIDTH-1:0]  tag;
  } entry_t;

  logic [DATA_WIDTH-1:0] ram [DEPTH];
  logic [IDX_W-1:0]      idx;
  logic                  req_oob;
  logic                  req_fire, rd_fire, wr_fire, pop;
  logic [LATENCY-1:0]    stage_valid;
  entry_t                stage_entry [LATENCY];
  logic [CNT_W-1:0]      outstanding;
  logic                  rst_done;
  logic                  stall;
  logic                  fifo_full, fifo_empty;
  entry_t                fifo_head;

  assign idx = bus.mem_req_addr[IDX_W-1:0];

  if (ADDR_WIDTH > IDX_W) begin : g_oob
    assign req_oob = |bus.mem_req_addr[ADDR_WIDTH-1:IDX_W];
  end else begin : g_no_oob
    assign req_oob = 1'b0;
  end

`ifdef LOCAL_MEM_STALL_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk) begin
    if (!reset) lfsr <= LOCAL_MEM_LFSR_SEED;
    else        lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end
  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // rst_done keeps ready low until the first edge sampled out of reset.
  assign bus.mem_req_ready = reset && rst_done && !stall && !fifo_full &&
                             (outstanding < CNT_W'(MAX_OUTSTANDING));
  assign req_fire = bus.mem_req_valid && bus.mem_req_ready;
  assign rd_fire  = req_fire && !bus.mem_req_rw;
  assign wr_fire  = req_fire && bus.mem_req_rw;
  assign pop      = bus.mem_rsp_valid && bus.mem_rsp_ready;

  always_ff @(posedge clk) begin
    if (wr_fire && !req_oob) begin
      for (int unsigned b = 0; b < DATA_WIDTH/8; b++) begin
        if (bus.mem_req_byteen[b]) ram[idx][b*8 +: 8] <= bus.mem_req_data[b*8 +: 8];
      end
    end
  end

  // RAM is read at acceptance; OOB reads carry zero data down the pipe.
  always_ff @(posedge clk) begin
    stage_entry[0] <= '{data: req_oob ? '0 : ram[idx], tag: bus.mem_req_tag};
    for (int unsigned i = 1; i < LATENCY; i++) stage_entry[i] <= stage_entry[i-1];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stage_valid <= '0;
      outstanding <= '0;
      oob_err     <= 1'b0;
      rst_done    <= 1'b0;
    end else begin
      rst_done       <= 1'b1;
      stage_valid[0] <= rd_fire;
      for (int unsigned i = 1; i < LATENCY; i++) stage_valid[i] <= stage_valid[i-1];
      if (req_fire && req_oob) oob_err <= 1'b1;
      case ({rd_fire, pop})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  local_mem_rsp_fifo #(
    .DEPTH   (MAX_OUTSTANDING),
    .entry_t (entry_t)
  ) u_rsp_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (stage_valid[LATENCY-1]),
    .push_entry (stage_entry[LATENCY-1]),
    .pop        (pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign bus.mem_rsp_valid = !fifo_empty;
  assign bus.mem_rsp_data  = fifo_head.data;
  assign bus.mem_rsp_tag   = fifo_head.tag;
endmodule

// File: tb/tb_local_mem_pipe.sv
// Bench for local_mem_pipe: directed scenarios plus randomized traffic
// checked against an in-order scoreboard built from an array memory model.
module tb_local_mem_pipe;
  localparam int unsigned DW = 32, AW = 16, TW = 8;
  localparam int unsigned DEPTH = 1024, LAT = 4, MAXO = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic oob_err;
  always #5 clk = ~clk;

  local_mem_pipe_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)) bus ();

  local_mem_pipe #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW),
    .DEPTH(DEPTH), .LATENCY(LAT), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .oob_err(oob_err)
  );

  typedef struct { logic [31:0] data; logic [7:0] tag; } exp_t;

  int          checks = 0, errors = 0, rsp_count = 0;
  logic [31:0] model_mem [DEPTH];
  bit          model_oob = 1'b0;
  bit          rand_rsp = 1'b0;
  exp_t        exp_q [$];

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // One clock: scoreboard the handshakes seen before the edge, then advance.
  task automatic step(output bit req_fired);
    bit rf, pf;
    int unsigned a;
    bit oob;
    exp_t e;
    if (rand_rsp) bus.mem_rsp_ready = ($urandom_range(3) != 0);
    #4;
    rf = bus.mem_req_valid && bus.mem_req_ready;
    pf = bus.mem_rsp_valid && bus.mem_rsp_ready;
    req_fired = rf;
    if (!reset) begin
      exp_q.delete();
      model_oob = 1'b0;
      req_fired = 1'b0;
    end else begin
      if (pf) begin
        chk("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("rsp_tag", 64'(bus.mem_rsp_tag), 64'(e.tag));
          chk("rsp_data", 64'(bus.mem_rsp_data), 64'(e.data));
          rsp_count++;
        end
      end
      if (rf) begin
        a = 32'(bus.mem_req_addr);
        oob = (a >= DEPTH);
        if (oob) model_oob = 1'b1;
        if (bus.mem_req_rw) begin
          if (!oob)
            for (int b = 0; b < 4; b++)
              if (bus.mem_req_byteen[b]) model_mem[a][8*b +: 8] = bus.mem_req_data[8*b +: 8];
        end else begin
          e.data = oob ? 32'd0 : model_mem[a];
          e.tag  = bus.mem_req_tag;
          exp_q.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit f;
    repeat (n) step(f);
  endtask

  task automatic req(input bit rw, input int unsigned addr, input logic [3:0] be,
                     input logic [31:0] d, input logic [7:0] tag);
    bit f = 1'b0;
    int n = 0;
    bus.mem_req_valid  = 1'b1;
    bus.mem_req_rw     = rw;
    bus.mem_req_addr   = AW'(addr);
    bus.mem_req_byteen = be;
    bus.mem_req_data   = d;
    bus.mem_req_tag    = tag;
    while (!f && n < 200) begin
      step(f);
      n++;
    end
    chk("req_accepted", 64'(f), 64'd1);
    bus.mem_req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget);
    bit f;
    int n = 0;
    while (!bus.mem_rsp_valid && n < budget) begin
      step(f);
      n++;
    end
    chk("rsp_arrived", 64'(bus.mem_rsp_valid), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit f;
    int reads;
    bus.mem_req_valid  = 1'b0;
    bus.mem_req_rw     = 1'b0;
    bus.mem_req_addr   = '0;
    bus.mem_req_byteen = '0;
    bus.mem_req_data   = '0;
    bus.mem_req_tag    = '0;
    bus.mem_rsp_ready  = 1'b1;

    // Reset for 3 edges, then ready rises on the first edge out of reset.
    #1;
    idle(3);
    chk("rst_req_ready", 64'(bus.mem_req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.mem_rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(bus.mem_rsp_data), 64'd0);
    chk("rst_rsp_tag", 64'(bus.mem_rsp_tag), 64'd0);
    chk("rst_oob_err", 64'(oob_err), 64'd0);
    reset = 1'b1;
    #1;
    chk("ready_before_edge", 64'(bus.mem_req_ready), 64'd0);
    #1;
    step(f);
`ifndef LOCAL_MEM_STALL_EN
    chk("ready_after_edge", 64'(bus.mem_req_ready), 64'd1);
`endif

    // Full write then read: response exactly LAT cycles after acceptance.
    req(1'b1, 5, 4'hF, 32'hDEADBEEF, 8'd0);
    req(1'b0, 5, 4'h0, 32'd0, 8'd3);
    chk("lat_cycle0", 64'(bus.mem_rsp_valid), 64'd0);
    for (int k = 1; k <= 4; k++) begin
      step(f);
      chk("lat_valid", 64'(bus.mem_rsp_valid), 64'(k == 4));
    end
    chk("lat_data", 64'(bus.mem_rsp_data), 64'hDEADBEEF);
    chk("lat_tag", 64'(bus.mem_rsp_tag), 64'd3);
    idle(1);

    // Byte-enable merge with read issued the cycle after the last write.
    req(1'b1, 7, 4'hF, 32'h11111111, 8'd0);
    req(1'b1, 7, 4'b0101, 32'hAAAAAAAA, 8'd0);
    req(1'b0, 7, 4'h0, 32'd0, 8'd9);
    wait_rsp(20);
    chk("byteen_data", 64'(bus.mem_rsp_data), 64'h11AA11AA);
    idle(1);

    // Credits: 8 reads with consumer stalled, then drain in order.
    bus.mem_rsp_ready = 1'b0;
    for (int t = 0; t < 8; t++) begin
      req(1'b0, (t % 2) ? 5 : 7, 4'h0, 32'd0, 8'(t));
      chk("outstanding_fill", 64'(dut.outstanding), 64'(t + 1));
    end
    chk("ready_low_full", 64'(bus.mem_req_ready), 64'd0);
    for (int k = 0; k < 6; k++) begin
      step(f);
      chk("hold_valid", 64'(bus.mem_rsp_valid), 64'd1);
      chk("hold_tag", 64'(bus.mem_rsp_tag), 64'd0);
      chk("hold_data", 64'(bus.mem_rsp_data), 64'(exp_q[0].data));
      chk("hold_ready", 64'(bus.mem_req_ready), 64'd0);
    end
    bus.mem_rsp_ready = 1'b1;
    step(f);
    chk("outstanding_after_pop", 64'(dut.outstanding), 64'd7);
`ifndef LOCAL_MEM_STALL_EN
    chk("ready_after_pop", 64'(bus.mem_req_ready), 64'd1);
`endif
    for (int k = 1; k < 8; k++) begin
      chk("burst_valid", 64'(bus.mem_rsp_valid), 64'd1);
      chk("burst_tag", 64'(bus.mem_rsp_tag), 64'(k));
      step(f);
    end
    chk("burst_drained", 64'(exp_q.size()), 64'd0);

    // Out-of-bounds read: zero data, sticky flag.
    req(1'b0, DEPTH + 2, 4'h0, 32'd0, 8'h55);
    chk("oob_set", 64'(oob_err), 64'd1);
    wait_rsp(20);
    chk("oob_data", 64'(bus.mem_rsp_data), 64'd0);
    idle(1);
    req(1'b1, 3, 4'hF, 32'h12345678, 8'd0);
    req(1'b0, 3, 4'h0, 32'd0, 8'd1);
    idle(8);
    chk("oob_sticky", 64'(oob_err), 64'd1);

    // Reset with reads in flight: nothing comes back afterwards.
    req(1'b0, 5, 4'h0, 32'd0, 8'd20);
    req(1'b0, 7, 4'h0, 32'd0, 8'd21);
    req(1'b0, 3, 4'h0, 32'd0, 8'd22);
    reset = 1'b0;
    idle(2);
    chk("midrst_outstanding", 64'(dut.outstanding), 64'd0);
    chk("midrst_oob", 64'(oob_err), 64'd0);
    reset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step(f);
      chk("no_stale_rsp", 64'(bus.mem_rsp_valid), 64'd0);
    end

    // Randomized traffic against the scoreboard.
    for (int i = 0; i < 64; i++) req(1'b1, i, 4'hF, $urandom, 8'd0);
    rand_rsp = 1'b1;
    rsp_count = 0;
    reads = 0;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(3) == 0)
        req(1'b1, ($urandom_range(15) == 0) ? DEPTH + $urandom_range(63) : $urandom_range(63),
            4'($urandom), $urandom, 8'd0);
      req(1'b0, ($urandom_range(31) == 0) ? DEPTH + $urandom_range(63) : $urandom_range(63),
          4'h0, 32'd0, 8'(i));
      reads++;
    end
    rand_rsp = 1'b0;
    bus.mem_rsp_ready = 1'b1;
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) step(f);
    chk("rand_drained", 64'(exp_q.size()), 64'd0);
    chk("rand_rsp_count", 64'(rsp_count), 64'(reads));
    chk("rand_outstanding", 64'(dut.outstanding), 64'd0);
    chk("rand_oob_flag", 64'(oob_err), 64'(model_oob));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
